// File: rtl/debug_resp_arbiter.sv
// ---------------------------------------------------------------------------
// debug_resp_arbiter
//
// Purpose:
//   Round-robin arbiter that collects debug response messages from several
//   independent producers. It writes each granted message as one frame into
//   the write side of the debug out-queue.
//   Frame layout: [channel-ID word] (only if ChanHeader=1), length word,
//   then len payload words. A length of 0 is a legal empty message.
//
// Ports:
//   i_clk      system clock, everything on the rising edge
//   i_rst      synchronous active-high reset (abandons any frame in flight)
//   i_req      per-channel "message pending", held until o_done[i]
//   i_len      per-channel payload length, slice i = [i*LenWidth +: LenWidth]
//   i_data     per-channel current payload word, slice i = [i*Width +: Width]
//   o_take     payload word of channel i consumed this cycle (combinational)
//   o_done     one-cycle pulse after the last word of channel i's frame
//   o_out_w    out-queue write request
//   o_out_wd   out-queue write data
//   i_out_wok  out-queue can accept; a word moves when o_out_w && i_out_wok
// ---------------------------------------------------------------------------
module debug_resp_arbiter #(
  parameter int Channels   = 4,
  parameter int Width      = 8,
  parameter int LenWidth   = 8,
  parameter int ChanHeader = 1
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic [Channels-1:0]          i_req,
  input  logic [Channels*LenWidth-1:0] i_len,
  input  logic [Channels*Width-1:0]    i_data,
  output logic [Channels-1:0]          o_take,
  output logic [Channels-1:0]          o_done,
  output logic                         o_out_w,
  output logic [Width-1:0]             o_out_wd,
  input  logic                         i_out_wok
);

  localparam int GrantWidth = (Channels > 1) ? $clog2(Channels) : 1;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] HDR_ID  = 2'd1;
  localparam logic [1:0] HDR_LEN = 2'd2;
  localparam logic [1:0] DATA    = 2'd3;

  // A frame opens with the ID word when it is enabled, otherwise with the length word.
  localparam logic [1:0] FIRST_HDR = (ChanHeader != 0) ? HDR_ID : HDR_LEN;

  logic [1:0]            r_state;
  logic [GrantWidth-1:0] r_grant;
  logic [GrantWidth-1:0] r_rrPtr;
  logic [LenWidth-1:0]   r_remaining;
  logic [Channels-1:0]   r_done;

  logic [Channels-1:0]   w_eligible;
  logic                  w_found;
  logic [GrantWidth-1:0] w_nextGrant;
  logic [LenWidth-1:0]   w_grantLen;
  logic [Width-1:0]      w_grantData;
  logic                  w_accept;

  // Mask channels whose done pulse is visible right now. The producer only
  // sees done at the end of this cycle, so its req is still high. Without
  // the mask the channel would be granted a second time.
  assign w_eligible = i_req & ~r_done;

  // Round-robin search. It starts one past the last grant and wraps, so
  // the last grant has the lowest priority.
  always_comb begin
    int idx;
    w_found     = 1'b0;
    w_nextGrant = '0;
    idx         = 0;
    for (int k = 1; k <= Channels; k++) begin
      idx = (int'(r_rrPtr) + k) % Channels;
      if (!w_found && w_eligible[idx]) begin
        w_found     = 1'b1;
        w_nextGrant = GrantWidth'(idx);
      end
    end
  end

  assign w_grantLen  = i_len[int'(w_nextGrant)*LenWidth +: LenWidth];
  assign w_grantData = i_data[int'(r_grant)*Width +: Width];
  assign w_accept    = o_out_w & i_out_wok;
  assign o_done      = r_done;

  // Output decode is driven only by state, so out_w/out_wd stay stable
  // during a stall. Payload goes from the granted producer straight to
  // out_wd with no register, and take mirrors out_wok during DATA.
  always_comb begin
    o_out_w  = 1'b0;
    o_out_wd = '0;
    o_take   = '0;
    case (r_state)
      HDR_ID: begin
        o_out_w  = 1'b1;
        o_out_wd = Width'(r_grant);
      end
      HDR_LEN: begin
        o_out_w  = 1'b1;
        o_out_wd = Width'(r_remaining);
      end
      DATA: begin
        o_out_w          = 1'b1;
        o_out_wd         = w_grantData;
        o_take[r_grant]  = i_out_wok;
      end
      default: begin
      end
    endcase
  end

  // Frame sequencer. The length is latched into r_remaining at grant time.
  // It is sent as the length word and then counts down the payload, so
  // later changes on i_len cannot affect a frame already in progress.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= IDLE;
      r_grant     <= '0;
      r_rrPtr     <= '0;
      r_remaining <= '0;
      r_done      <= '0;
    end else begin
      r_done <= '0;
      case (r_state)
        IDLE: begin
          if (w_found) begin
            r_grant     <= w_nextGrant;
            r_rrPtr     <= w_nextGrant;
            r_remaining <= w_grantLen;
            r_state     <= FIRST_HDR;
          end
        end
        HDR_ID: begin
          if (w_accept) begin
            r_state <= HDR_LEN;
          end
        end
        HDR_LEN: begin
          if (w_accept) begin
            if (r_remaining == '0) begin
              r_state         <= IDLE;
              r_done[r_grant] <= 1'b1;
            end else begin
              r_state <= DATA;
            end
          end
        end
        DATA: begin
          if (w_accept) begin
            r_remaining <= r_remaining - 1'b1;
            if (r_remaining == LenWidth'(1)) begin
              r_state         <= IDLE;
              r_done[r_grant] <= 1'b1;
            end
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_debug_resp_arbiter.sv
// ---------------------------------------------------------------------------
// tb_debug_resp_arbiter
//
// Purpose:
//   Self-checking bench for debug_resp_arbiter. dut1 uses 4 channels, 8-bit
//   words and channel-ID headers. dut2 uses 16-bit words, 8-bit lengths and
//   no ID header. Every frame the bench launches pushes its expected words
//   onto a scoreboard queue. Each accepted out-queue word is popped from the
//   queue and compared, together with its take and done behaviour.
// ---------------------------------------------------------------------------
module tb_debug_resp_arbiter;

  localparam int NumCh1 = 4;
  localparam int NumCh2 = 2;

  typedef struct {
    logic [15:0] word;
    logic        isData;
    logic        first;
    logic        last;
    int          chan;
  } ExpWord;

  logic        clk;
  logic        rst;

  logic [3:0]  req1;
  logic [31:0] len1;
  logic [31:0] data1;
  logic [3:0]  take1;
  logic [3:0]  done1;
  logic        outW1;
  logic [7:0]  outWd1;
  logic        outWok1;

  logic [1:0]  req2;
  logic [15:0] len2;
  logic [31:0] data2;
  logic [1:0]  take2;
  logic [1:0]  done2;
  logic        outW2;
  logic [15:0] outWd2;
  logic        outWok2;

  logic [7:0]  base1 [NumCh1];
  logic [15:0] base2 [NumCh2];
  int          ptr1 [NumCh1];
  int          ptr2 [NumCh2];
  int          takeCnt1 [NumCh1];
  int          takeCnt2 [NumCh2];

  ExpWord      sb1 [$];
  ExpWord      sb2 [$];
  int          starts1 [$];
  int          pendDone1;
  int          pendDone2;
  int          firstCyc1, lastCyc1, firstCyc2, lastCyc2;
  int          cycle;
  int          checksDone;
  int          checksPassed;

  debug_resp_arbiter #(
    .Channels(4), .Width(8), .LenWidth(8), .ChanHeader(1)
  ) dut1 (
    .i_clk(clk), .i_rst(rst), .i_req(req1), .i_len(len1), .i_data(data1),
    .o_take(take1), .o_done(done1), .o_out_w(outW1), .o_out_wd(outWd1),
    .i_out_wok(outWok1)
  );

  debug_resp_arbiter #(
    .Channels(2), .Width(16), .LenWidth(8), .ChanHeader(0)
  ) dut2 (
    .i_clk(clk), .i_rst(rst), .i_req(req2), .i_len(len2), .i_data(data2),
    .o_take(take2), .o_done(done2), .o_out_w(outW2), .o_out_wd(outWd2),
    .i_out_wok(outWok2)
  );

  // Free-running clock, period 10.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Safety net so a wedged run still terminates.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  // Single comparison point; every check goes through here.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checksDone++;
    if (observed === expected) begin
      checksPassed++;
    end else begin
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)",
               tag, observed, expected, cycle);
    end
  endtask

  // Producers present base + number of words already taken.
  task automatic driveData();
    for (int i = 0; i < NumCh1; i++) data1[i*8 +: 8] = base1[i] + 8'(ptr1[i]);
    for (int i = 0; i < NumCh2; i++) data2[i*16 +: 16] = base2[i] + 16'(ptr2[i]);
  endtask

  // One clock: compare at the falling edge, then update the producer
  // models just after the rising edge.
  task automatic stepCycle();
    ExpWord     e;
    logic [3:0] expTake1, expDone1, takeSeen1, doneSeen1;
    logic [1:0] expTake2, expDone2, takeSeen2, doneSeen2;
    @(negedge clk);
    cycle++;

    expTake1 = '0;
    expDone1 = '0;
    if (pendDone1 >= 0) expDone1[pendDone1] = 1'b1;
    pendDone1 = -1;
    if (outW1 && outWok1) begin
      if (sb1.size() == 0) begin
        checkOutput("dut1_unexpected_word", 32'(sb1.size()), 32'd1);
      end else begin
        e = sb1.pop_front();
        checkOutput("dut1_word", 32'(outWd1), 32'(e.word));
        if (e.isData) expTake1[e.chan] = 1'b1;
        if (e.first) begin
          firstCyc1 = cycle;
          starts1.push_back(cycle);
        end
        if (e.last) begin
          lastCyc1  = cycle;
          pendDone1 = e.chan;
        end
      end
    end
    if (take1 != 0 || expTake1 != 0) checkOutput("dut1_take", 32'(take1), 32'(expTake1));
    if (done1 != 0 || expDone1 != 0) checkOutput("dut1_done", 32'(done1), 32'(expDone1));

    expTake2 = '0;
    expDone2 = '0;
    if (pendDone2 >= 0) expDone2[pendDone2] = 1'b1;
    pendDone2 = -1;
    if (outW2 && outWok2) begin
      if (sb2.size() == 0) begin
        checkOutput("dut2_unexpected_word", 32'(sb2.size()), 32'd1);
      end else begin
        e = sb2.pop_front();
        checkOutput("dut2_word", 32'(outWd2), 32'(e.word));
        if (e.isData) expTake2[e.chan] = 1'b1;
        if (e.first) firstCyc2 = cycle;
        if (e.last) begin
          lastCyc2  = cycle;
          pendDone2 = e.chan;
        end
      end
    end
    if (take2 != 0 || expTake2 != 0) checkOutput("dut2_take", 32'(take2), 32'(expTake2));
    if (done2 != 0 || expDone2 != 0) checkOutput("dut2_done", 32'(done2), 32'(expDone2));

    takeSeen1 = take1;
    doneSeen1 = done1;
    takeSeen2 = take2;
    doneSeen2 = done2;
    for (int i = 0; i < NumCh1; i++) if (takeSeen1[i]) takeCnt1[i]++;
    for (int i = 0; i < NumCh2; i++) if (takeSeen2[i]) takeCnt2[i]++;

    @(posedge clk);
    #1;
    for (int i = 0; i < NumCh1; i++) begin
      if (takeSeen1[i]) ptr1[i]++;
      if (doneSeen1[i]) req1[i] = 1'b0;
    end
    for (int i = 0; i < NumCh2; i++) begin
      if (takeSeen2[i]) ptr2[i]++;
      if (doneSeen2[i]) req2[i] = 1'b0;
    end
    driveData();
  endtask

  // Launch a frame on dut1 and queue the words it must produce.
  task automatic applyStimulus(input int chan, input int lenVal, input logic [7:0] baseVal);
    ExpWord e;
    len1[chan*8 +: 8] = 8'(lenVal);
    base1[chan]       = baseVal;
    ptr1[chan]        = 0;
    takeCnt1[chan]    = 0;
    e.chan = chan;
    e.word = 16'(chan);   e.isData = 1'b0; e.first = 1'b1; e.last = 1'b0;
    sb1.push_back(e);
    e.word = 16'(lenVal); e.first = 1'b0;  e.last = (lenVal == 0);
    sb1.push_back(e);
    for (int k = 0; k < lenVal; k++) begin
      e.word   = 16'(8'(baseVal + 8'(k)));
      e.isData = 1'b1;
      e.last   = (k == lenVal - 1);
      sb1.push_back(e);
    end
    req1[chan] = 1'b1;
    driveData();
  endtask

  // Launch a frame on dut2 (length word first, no ID word).
  task automatic applyStimulus2(input int chan, input int lenVal, input logic [15:0] baseVal);
    ExpWord e;
    len2[chan*8 +: 8] = 8'(lenVal);
    base2[chan]       = baseVal;
    ptr2[chan]        = 0;
    takeCnt2[chan]    = 0;
    e.chan = chan;
    e.word = 16'(lenVal); e.isData = 1'b0; e.first = 1'b1; e.last = (lenVal == 0);
    sb2.push_back(e);
    for (int k = 0; k < lenVal; k++) begin
      e.word   = baseVal + 16'(k);
      e.isData = 1'b1;
      e.first  = 1'b0;
      e.last   = (k == lenVal - 1);
      sb2.push_back(e);
    end
    req2[chan] = 1'b1;
    driveData();
  endtask

  // Run until all frames are drained and acknowledged, bounded by budget.
  task automatic waitIdle(input int budget);
    int  n;
    logic busy;
    n    = 0;
    busy = 1'b1;
    while (busy && n < budget) begin
      stepCycle();
      n++;
      busy = (sb1.size() != 0) || (sb2.size() != 0) || (pendDone1 >= 0) ||
             (pendDone2 >= 0) || (req1 != 0) || (req2 != 0);
    end
    if (busy) checkOutput("timeout_words_left", 32'(sb1.size() + sb2.size()), 32'd0);
    stepCycle();
  endtask

  // Reset both instances while idle and clear the bench-side models.
  task automatic applyReset();
    rst  = 1'b1;
    req1 = '0;
    req2 = '0;
    sb1.delete();
    sb2.delete();
    pendDone1 = -1;
    pendDone2 = -1;
    stepCycle();
    stepCycle();
    rst = 1'b0;
  endtask

  initial begin
    int n;
    checksDone   = 0;
    checksPassed = 0;
    cycle        = 0;
    pendDone1    = -1;
    pendDone2    = -1;
    firstCyc1 = 0; lastCyc1 = 0; firstCyc2 = 0; lastCyc2 = 0;
    rst     = 1'b1;
    req1    = '0; len1 = '0; data1 = '0; outWok1 = 1'b1;
    req2    = '0; len2 = '0; data2 = '0; outWok2 = 1'b1;
    for (int i = 0; i < NumCh1; i++) begin base1[i] = '0; ptr1[i] = 0; takeCnt1[i] = 0; end
    for (int i = 0; i < NumCh2; i++) begin base2[i] = '0; ptr2[i] = 0; takeCnt2[i] = 0; end

    // Reset state
    stepCycle();
    stepCycle();
    checkOutput("rst_out_w",  32'(outW1),  32'd0);
    checkOutput("rst_out_wd", 32'(outWd1), 32'd0);
    checkOutput("rst_done",   32'(done1),  32'd0);
    checkOutput("rst_take",   32'(take1),  32'd0);
    checkOutput("rst_out_w2", 32'(outW2),  32'd0);
    rst = 1'b0;
    stepCycle();

    // Single channel 2 frame: 02,03,A0,A1,A2 back to back
    $display("[TB] single frame on channel 2");
    applyStimulus(2, 3, 8'hA0);
    waitIdle(30);
    checkOutput("t1_frame_span", 32'(lastCyc1 - firstCyc1), 32'd4);
    checkOutput("t1_take_count", 32'(takeCnt1[2]), 32'd3);

    // All channels at once right after reset: order 1,2,3,0, one idle gap
    $display("[TB] all channels requesting");
    applyReset();
    starts1.delete();
    applyStimulus(1, 1, 8'h11);
    applyStimulus(2, 1, 8'h22);
    applyStimulus(3, 1, 8'h33);
    applyStimulus(0, 1, 8'h44);
    waitIdle(60);
    checkOutput("t2_frame_count", 32'(starts1.size()), 32'd4);
    for (int i = 1; i < starts1.size(); i++)
      checkOutput("t2_frame_spacing", 32'(starts1[i] - starts1[i-1]), 32'd4);

    // Stall on the second payload word for 5 cycles
    $display("[TB] stall during payload");
    applyStimulus(0, 4, 8'hC0);
    n = 0;
    while (takeCnt1[0] < 1 && n < 20) begin stepCycle(); n++; end
    outWok1 = 1'b0;
    for (int s = 0; s < 5; s++) begin
      stepCycle();
      checkOutput("t3_stall_out_w",  32'(outW1),  32'd1);
      checkOutput("t3_stall_out_wd", 32'(outWd1), 32'hC1);
      checkOutput("t3_stall_take",   32'(take1),  32'd0);
    end
    outWok1 = 1'b1;
    waitIdle(40);
    checkOutput("t3_take_count", 32'(takeCnt1[0]), 32'd4);

    // Empty message on channel 3
    $display("[TB] zero-length message");
    applyStimulus(3, 0, 8'h00);
    waitIdle(20);
    checkOutput("t4_frame_span", 32'(lastCyc1 - firstCyc1), 32'd1);
    checkOutput("t4_take_count", 32'(takeCnt1[3]), 32'd0);

    // Reset in the middle of a long frame, then a fresh frame on channel 1
    $display("[TB] reset mid-frame");
    applyStimulus(0, 10, 8'h50);
    n = 0;
    while (takeCnt1[0] < 4 && n < 40) begin stepCycle(); n++; end
    rst = 1'b1;
    stepCycle();
    rst     = 1'b0;
    req1[0] = 1'b0;
    sb1.delete();
    pendDone1 = -1;
    checkOutput("t5_out_w_after_rst",  32'(outW1),  32'd0);
    checkOutput("t5_done_after_rst",   32'(done1),  32'd0);
    checkOutput("t5_take_after_rst",   32'(take1),  32'd0);
    checkOutput("t5_out_wd_after_rst", 32'(outWd1), 32'd0);
    stepCycle();
    applyStimulus(1, 2, 8'h10);
    waitIdle(40);
    checkOutput("t5_take_count", 32'(takeCnt1[1]), 32'd2);

    // Maximum length, no ID header, 16-bit words
    $display("[TB] 255-word frame without ID header");
    applyStimulus2(0, 255, 16'hB000);
    waitIdle(400);
    checkOutput("t6_frame_span", 32'(lastCyc2 - firstCyc2), 32'd255);
    checkOutput("t6_take_count", 32'(takeCnt2[0]), 32'd255);

    $display("%0d/%0d checks passed", checksPassed, checksDone);
    $finish;
  end

endmodule
